// File: rtl/ej32_rstack.sv
// ej32_rstack: return-stack unit for eJ32.
// TOS is held in a register with a registered zero flag, so DNEXT resolves in one cycle.
// Also provides indexed LOAD reads, a live depth count and sticky error flags.
// Optional feature macro: EJ32_RS_TRAP_EN enables overflow/underflow trapping.
// When the macro is defined, an offending op is suppressed and a sticky flag is set.
// When it is undefined, a PUSH at full wraps circularly, and POP or DNEXT at empty does nothing.
module ej32_rstack #(
  parameter int unsigned DSZ = 32,
  parameter int unsigned SSZ = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [2:0]     op,
  input  logic [DSZ-1:0] d,
  input  logic [SSZ-1:0] idx,
  input  logic           clr_err,
  output logic [DSZ-1:0] r_o,
  output logic           rz_o,
  output logic [SSZ:0]   cnt_o,
  output logic           busy_o,
  output logic           ld_v_o,
  output logic [DSZ-1:0] ld_d_o,
  output logic           nxt_v_o,
  output logic           nxt_tk_o,
  output logic           ovf_o,
  output logic           unf_o
);
  localparam int unsigned DEPTH = 2**SSZ;
  localparam logic [SSZ:0] L_FULL = (SSZ+1)'(DEPTH);
  localparam logic [SSZ:0] L_ONE  = (SSZ+1)'(1);

  typedef enum logic [2:0] {
    OP_NOP = 3'd0, OP_PUSH = 3'd1, OP_POP = 3'd2, OP_MOVE = 3'd3,
    OP_LOAD = 3'd4, OP_DNEXT = 3'd5
  } op_e;

  typedef enum logic {S_IDLE, S_LOAD} state_e;

  // Entries below TOS live in a power-of-two circular buffer addressed by r_sp (the next
  // free slot). A PUSH at full therefore overwrites the oldest entry without any shifting.
  // Only the cnt-1 slots nearest r_sp hold live entries.
  logic [DSZ-1:0] r_mem [DEPTH];
  logic [DSZ-1:0] r_r, r_ld_d;
  logic [SSZ-1:0] r_sp, r_idx;
  logic [SSZ:0]   r_cnt;
  logic           r_rz, r_ld_v, r_nxt_v, r_nxt_tk;
  state_e         r_state;

  logic [DSZ-1:0] w_r_nxt, w_mem_top, w_ld_d;
  logic [SSZ-1:0] w_sp_nxt;
  logic [SSZ:0]   w_cnt_nxt;
  logic           w_we, w_nxt_v, w_nxt_tk, w_ld_go, w_full, w_empty, w_ld_oob;

  assign w_full    = (r_cnt == L_FULL);
  assign w_empty   = (r_cnt == '0);
  assign w_mem_top = r_mem[r_sp - 1'b1];
  assign w_ld_oob  = ({1'b0, r_idx} >= r_cnt);
  assign w_ld_d    = w_ld_oob ? '0 : ((r_idx == '0) ? r_r : r_mem[r_sp - r_idx]);

`ifdef EJ32_RS_TRAP_EN
  logic w_ovf, w_unf, r_ovf, r_unf;
`else
  logic w_unused;
  assign w_unused = clr_err;
`endif

  // Next-state decode for the stack proper and the DNEXT result
  always_comb begin
    w_r_nxt   = r_r;
    w_cnt_nxt = r_cnt;
    w_sp_nxt  = r_sp;
    w_we      = 1'b0;
    w_nxt_v   = 1'b0;
    w_nxt_tk  = r_nxt_tk;
    w_ld_go   = 1'b0;
`ifdef EJ32_RS_TRAP_EN
    w_ovf     = 1'b0;
    w_unf     = (r_state == S_LOAD) && w_ld_oob;
`endif
    if (en && r_state == S_IDLE) begin
      case (op)
        OP_PUSH, OP_MOVE: begin
          if (op == OP_MOVE && !w_empty) begin
            w_r_nxt = d;
          end else if (w_full) begin
`ifdef EJ32_RS_TRAP_EN
            w_ovf = 1'b1;
`else
            w_we     = 1'b1;
            w_sp_nxt = r_sp + 1'b1;
            w_r_nxt  = d;
`endif
          end else begin
            if (!w_empty) begin
              w_we     = 1'b1;
              w_sp_nxt = r_sp + 1'b1;
            end
            w_r_nxt   = d;
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        OP_POP, OP_DNEXT: begin
          if (op == OP_DNEXT) begin
            w_nxt_v  = 1'b1;
            w_nxt_tk = !w_empty && !r_rz;
          end
`ifdef EJ32_RS_TRAP_EN
          if (w_empty) w_unf = 1'b1;
`endif
          if (op == OP_DNEXT && !w_empty && !r_rz) begin
            w_r_nxt = r_r - 1'b1;
          end else if (!w_empty) begin
            w_cnt_nxt = r_cnt - 1'b1;
            if (r_cnt == L_ONE) begin
              w_r_nxt = '0;
            end else begin
              w_r_nxt  = w_mem_top;
              w_sp_nxt = r_sp - 1'b1;
            end
          end
        end
        OP_LOAD: w_ld_go = 1'b1;
        default: ;
      endcase
    end
  end

  // Stack register, pulses and the LOAD sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_r      <= '0;
      r_rz     <= 1'b1;
      r_cnt    <= '0;
      r_sp     <= '0;
      r_ld_v   <= 1'b0;
      r_ld_d   <= '0;
      r_nxt_v  <= 1'b0;
      r_nxt_tk <= 1'b0;
    end else begin
      r_r      <= w_r_nxt;
      r_rz     <= (w_r_nxt == '0);
      r_cnt    <= w_cnt_nxt;
      r_sp     <= w_sp_nxt;
      r_nxt_v  <= w_nxt_v;
      r_nxt_tk <= w_nxt_tk;
      r_ld_v   <= 1'b0;
      case (r_state)
        S_IDLE: if (w_ld_go) begin
          r_state <= S_LOAD;
          r_idx   <= idx;
        end
        S_LOAD: begin
          r_state <= S_IDLE;
          r_ld_v  <= 1'b1;
          r_ld_d  <= w_ld_d;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Array write of the outgoing TOS on PUSH
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_sp] <= r_r;
  end

`ifdef EJ32_RS_TRAP_EN
  // Sticky error flags; a new error on a clearing edge keeps its flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (en && clr_err) begin
      r_ovf <= w_ovf;
      r_unf <= w_unf;
    end else begin
      r_ovf <= r_ovf | w_ovf;
      r_unf <= r_unf | w_unf;
    end
  end
  assign ovf_o = r_ovf;
  assign unf_o = r_unf;
`else
  assign ovf_o = 1'b0;
  assign unf_o = 1'b0;
`endif

  assign r_o      = r_r;
  assign rz_o     = r_rz;
  assign cnt_o    = r_cnt;
  assign busy_o   = (r_state == S_LOAD);
  assign ld_v_o   = r_ld_v;
  assign ld_d_o   = r_ld_d;
  assign nxt_v_o  = r_nxt_v;
  assign nxt_tk_o = r_nxt_tk;
endmodule

// File: tb/tb_ej32_rstack.sv
// Directed testbench for ej32_rstack: a default-size instance and a 4-entry instance.
module tb_ej32_rstack;
`ifdef EJ32_RS_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, MOVE = 3'd3,
                         LOAD = 3'd4, DNEXT = 3'd5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, clr_err;
  logic [2:0] op;
  logic [31:0] d;
  logic [5:0] idx;
  logic [31:0] r_o, ld_d_o;
  logic rz_o, busy_o, ld_v_o, nxt_v_o, nxt_tk_o, ovf_o, unf_o;
  logic [6:0] cnt_o;

  logic s_clr;
  logic [2:0] s_op;
  logic [31:0] s_d;
  logic [1:0] s_idx;
  logic [31:0] s_r, s_ldd;
  logic s_rz, s_busy, s_ldv, s_nv, s_ntk, s_ovf, s_unf;
  logic [2:0] s_cnt;

  int npass = 0;
  int ntot = 0;

  ej32_rstack #(.DSZ(32), .SSZ(6)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .op(op), .d(d), .idx(idx), .clr_err(clr_err),
    .r_o(r_o), .rz_o(rz_o), .cnt_o(cnt_o), .busy_o(busy_o), .ld_v_o(ld_v_o),
    .ld_d_o(ld_d_o), .nxt_v_o(nxt_v_o), .nxt_tk_o(nxt_tk_o), .ovf_o(ovf_o), .unf_o(unf_o)
  );

  ej32_rstack #(.DSZ(32), .SSZ(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .op(s_op), .d(s_d), .idx(s_idx), .clr_err(s_clr),
    .r_o(s_r), .rz_o(s_rz), .cnt_o(s_cnt), .busy_o(s_busy), .ld_v_o(s_ldv),
    .ld_d_o(s_ldd), .nxt_v_o(s_nv), .nxt_tk_o(s_ntk), .ovf_o(s_ovf), .unf_o(s_unf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input logic [2:0] o, input logic [31:0] dd, input logic [5:0] ix,
                      input logic ce);
    op = o; d = dd; idx = ix; clr_err = ce;
    @(posedge clk); #1;
    op = NOP; clr_err = 1'b0;
  endtask

  task automatic step_s(input logic [2:0] o, input logic [31:0] dd, input logic [1:0] ix,
                        input logic ce);
    s_op = o; s_d = dd; s_idx = ix; s_clr = ce;
    @(posedge clk); #1;
    s_op = NOP; s_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; op = NOP; d = '0; idx = '0; clr_err = 1'b0;
    s_op = NOP; s_d = '0; s_idx = '0; s_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_r", r_o, 0);       chk("rst_rz", rz_o, 1);     chk("rst_cnt", cnt_o, 0);
    chk("rst_busy", busy_o, 0); chk("rst_ldv", ld_v_o, 0);  chk("rst_ldd", ld_d_o, 0);
    chk("rst_nv", nxt_v_o, 0);  chk("rst_ntk", nxt_tk_o, 0);
    chk("rst_ovf", ovf_o, 0);   chk("rst_unf", unf_o, 0);
    rst_n = 1'b1;

    // push / pop
    step(PUSH, 5, 0, 0); step(PUSH, 7, 0, 0); step(PUSH, 9, 0, 0);
    chk("push_r", r_o, 9); chk("push_cnt", cnt_o, 3); chk("push_rz", rz_o, 0);
    step(POP, 0, 0, 0);  chk("pop1_r", r_o, 7); chk("pop1_cnt", cnt_o, 2);
    step(POP, 0, 0, 0);  chk("pop2_r", r_o, 5); chk("pop2_cnt", cnt_o, 1);

    // donext loop
    step(PUSH, 2, 0, 0);
    step(DNEXT, 0, 0, 0);
    chk("dn1_v", nxt_v_o, 1); chk("dn1_tk", nxt_tk_o, 1); chk("dn1_r", r_o, 1); chk("dn1_rz", rz_o, 0);
    step(DNEXT, 0, 0, 0);
    chk("dn2_tk", nxt_tk_o, 1); chk("dn2_r", r_o, 0); chk("dn2_rz", rz_o, 1);
    step(DNEXT, 0, 0, 0);
    chk("dn3_v", nxt_v_o, 1); chk("dn3_tk", nxt_tk_o, 0); chk("dn3_r", r_o, 5);
    chk("dn3_cnt", cnt_o, 1); chk("dn3_rz", rz_o, 0);
    step(NOP, 0, 0, 0);
    chk("dn_pulse", nxt_v_o, 0); chk("dn_hold", nxt_tk_o, 0);

    // empty pop
    step(POP, 0, 0, 0);
    chk("pop_last_r", r_o, 0); chk("pop_last_cnt", cnt_o, 0); chk("pop_last_rz", rz_o, 1);
    step(POP, 0, 0, 0);
    chk("epop_cnt", cnt_o, 0); chk("epop_unf", unf_o, TRAP);
    step(NOP, 0, 0, 1);
    chk("clr_unf", unf_o, 0);

    // indexed loads
    step(PUSH, 10, 0, 0); step(PUSH, 20, 0, 0); step(PUSH, 30, 0, 0);
    step(LOAD, 0, 2, 0);
    chk("ld_busy", busy_o, 1); chk("ld_v0", ld_v_o, 0);
    step(PUSH, 99, 0, 0);
    chk("ld_busy_end", busy_o, 0); chk("ld_v", ld_v_o, 1); chk("ld_d2", ld_d_o, 10);
    chk("ld_ign_cnt", cnt_o, 3); chk("ld_ign_r", r_o, 30);
    step(NOP, 0, 0, 0); chk("ld_pulse", ld_v_o, 0);
    step(LOAD, 0, 1, 0); step(NOP, 0, 0, 0); chk("ld_d1", ld_d_o, 20);
    step(LOAD, 0, 0, 0); step(NOP, 0, 0, 0); chk("ld_d0", ld_d_o, 30);
    step(LOAD, 0, 3, 0); step(NOP, 0, 0, 0);
    chk("ld_oob_v", ld_v_o, 1); chk("ld_oob_d", ld_d_o, 0);
    chk("ld_oob_unf", unf_o, TRAP); chk("ld_oob_cnt", cnt_o, 3);
    step(NOP, 0, 0, 1); chk("clr_unf2", unf_o, 0);

    // modulo decrement, enable gating, move on empty
    step(POP, 0, 0, 0); step(POP, 0, 0, 0);
    chk("pp_r", r_o, 10); chk("pp_cnt", cnt_o, 1);
    step(MOVE, 32'hFFFF_FFFF, 0, 0);
    chk("mv_r", r_o, 32'hFFFF_FFFF); chk("mv_cnt", cnt_o, 1);
    step(DNEXT, 0, 0, 0);
    chk("dnw_r", r_o, 32'hFFFF_FFFE); chk("dnw_tk", nxt_tk_o, 1);
    en = 1'b0;
    step(PUSH, 123, 0, 0);
    chk("en0_r", r_o, 32'hFFFF_FFFE); chk("en0_cnt", cnt_o, 1); chk("en0_nv", nxt_v_o, 0);
    en = 1'b1;
    step(POP, 0, 0, 0);
    step(MOVE, 32'h44, 0, 0);
    chk("mv0_r", r_o, 32'h44); chk("mv0_cnt", cnt_o, 1);
    step(POP, 0, 0, 0);
    step(DNEXT, 0, 0, 0);
    chk("edn_v", nxt_v_o, 1); chk("edn_tk", nxt_tk_o, 0);
    chk("edn_cnt", cnt_o, 0); chk("edn_unf", unf_o, TRAP);
    step(POP, 0, 0, 1);
    chk("clr_vs_err", unf_o, TRAP);
    step(NOP, 0, 0, 1);
    chk("clr_unf3", unf_o, 0);

    // overflow on the 4-entry instance
    for (int unsigned i = 1; i <= 5; i++) step_s(PUSH, i, 0, 0);
    chk("ovf_cnt", s_cnt, 4); chk("ovf_r", s_r, TRAP ? 4 : 5); chk("ovf_flag", s_ovf, TRAP);
    step_s(LOAD, 0, 3, 0); step_s(NOP, 0, 0, 0);
    chk("ovf_ld3", s_ldd, TRAP ? 1 : 2);
    step_s(NOP, 0, 0, 1);
    chk("ovf_clr", s_ovf, 0);
    step_s(POP, 0, 0, 0);
    chk("ovf_pop_r", s_r, TRAP ? 3 : 4); chk("ovf_pop_cnt", s_cnt, 3);

    // asynchronous reset in the middle of a LOAD
    step(PUSH, 77, 0, 0);
    step(LOAD, 0, 0, 0);
    chk("mr_busy", busy_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_busy0", busy_o, 0); chk("mr_ldv0", ld_v_o, 0); chk("mr_cnt", cnt_o, 0);
    chk("mr_rz", rz_o, 1); chk("mr_s_cnt", s_cnt, 0);
    @(posedge clk); #1;
    chk("mr_ldv1", ld_v_o, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mr_ldv2", ld_v_o, 0); chk("mr_busy2", busy_o, 0); chk("mr_r", r_o, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
